// File: rtl/fp_multiply_pipe.sv
// Pipelined IEEE-754 multiplier (unpack/classify -> significand multiply -> normalise/round/pack).
// Latency 3 cycles from accepted operands to out_valid; one result per cycle while out_ready=1.
// Backpressure: all stages stall together when out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + op_a/op_b operand handshake;
//        out_valid/out_ready + result/flags result handshake, flags = {invalid, overflow, underflow, inexact, zero}.
module fp_multiply_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags
);
    // Exponent sum is carried two bits wider than the field so it can hold
    // -bias up to twice the largest exponent plus normalise/round carries.
    localparam int EW = EXP_W + 2;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;

    localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- stage 1: unpack / classify ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign {sa, ea, fa} = op_a;
    assign {sb, eb, fb} = op_b;

    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
    always_comb begin
        // Subnormals are flushed: any zero exponent classifies as zero.
        zero_a = (ea == '0);
        zero_b = (eb == '0);
        inf_a  = (ea == EXP_ONES) && (fa == '0);
        inf_b  = (eb == EXP_ONES) && (fb == '0);
        nan_a  = (ea == EXP_ONES) && (fa != '0);
        nan_b  = (eb == EXP_ONES) && (fb != '0);
        snan_a = nan_a && !fa[MAN_W-1];
        snan_b = nan_b && !fb[MAN_W-1];
    end

    logic          s1_valid, s1_sign, s1_nan, s1_snan, s1_inf, s1_zero;
    logic [EW-1:0] s1_esum;
    logic [SW-1:0] s1_ma, s1_mb;

    // ---------------- stage 2: significand multiply ----------------
    logic          s2_valid, s2_sign, s2_nan, s2_snan, s2_inf, s2_zero;
    logic [EW-1:0] s2_esum;
    logic [PW-1:0] s2_prod;

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [PW-2:0]  norm;
    logic [MAN_W-1:0] frac_t;
    logic           guard, sticky, rnd_up;
    logic [MAN_W:0] frac_r;
    logic [EW-1:0]  esum_f;
    logic           ovf, unf;
    logic [W-1:0]   res_c;
    logic [4:0]     flg_c;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); align so the
        // leading one sits just above bit 2*MAN_W of norm.
        norm   = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        frac_t = norm[2*MAN_W:MAN_W+1];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        rnd_up = guard && (sticky || frac_t[0]);
        // A carry out of the fraction leaves its low bits all zero, which is
        // exactly the renormalised 1.000... significand.
        frac_r = {1'b0, frac_t} + SW'(rnd_up);
        esum_f = s2_esum + EW'(s2_prod[PW-1]) + EW'(frac_r[MAN_W]);
        ovf    = !esum_f[EW-1] && (esum_f >= EMAX);
        unf    = esum_f[EW-1] || (esum_f == '0);

        res_c = {s2_sign, esum_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
        flg_c = {3'b000, guard || sticky, 1'b0};
        if (s2_nan || (s2_inf && s2_zero)) begin
            // inf x zero is always invalid; a NaN operand only when signalling.
            res_c = QNAN;
            flg_c = {s2_snan || !s2_nan, 4'b0000};
        end else if (s2_inf) begin
            res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            flg_c = 5'b00000;
        end else if (s2_zero) begin
            res_c = {s2_sign, {(W - 1){1'b0}}};
            flg_c = 5'b00001;
        end else if (ovf) begin
            res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            flg_c = 5'b01010;
        end else if (unf) begin
            res_c = {s2_sign, {(W - 1){1'b0}}};
            flg_c = 5'b00111;
        end
    end

    // Control and visible outputs: cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res_c;
                flags  <= flg_c;
            end
        end
    end

    // Datapath registers: qualified by the stage valid bits, no reset needed.
    always_ff @(posedge clk) begin
        if (advance) begin
            if (in_valid) begin
                s1_sign <= sa ^ sb;
                s1_esum <= EW'(ea) + EW'(eb) - BIAS;
                s1_ma   <= {1'b1, fa};
                s1_mb   <= {1'b1, fb};
                s1_nan  <= nan_a || nan_b;
                s1_snan <= snan_a || snan_b;
                s1_inf  <= inf_a || inf_b;
                s1_zero <= zero_a || zero_b;
            end
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_esum <= s1_esum;
                s2_prod <= PW'(s1_ma) * PW'(s1_mb);
                s2_nan  <= s1_nan;
                s2_snan <= s1_snan;
                s2_inf  <= s1_inf;
                s2_zero <= s1_zero;
            end
        end
    end
endmodule
